uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receive side of the UART link; mirror of the TX serializer/output-mux path.
//  Oversamples rx_in, detects start, majority-votes each bit, checks parity and stop.
//  Delivers a parallel byte plus a one-cycle data_valid strobe to the ALU/control side.
//  Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, one stop(1).
// PARAMETERS
//  DATA_WIDTH   8  data bits per frame
//  PRESCALE_W   6  width of prescale input and edge counter
// PORTS
//  clk         in   1           system clock; all logic on posedge
//  rst         in   1           reset, synchronous, active-low
//  rx_in       in   1           serial line, idle high, asynchronous to clk
//  prescale    in   PRESCALE_W  clocks per bit; even, 8..32; other values undefined
//  par_en      in   1           1 = parity bit present
//  par_typ     in   1           0 = even, 1 = odd
//  p_data      out  DATA_WIDTH  received byte; holds until the next good frame
//  data_valid  out  1           1-cycle pulse: p_data updated, frame good
//  par_err     out  1           1-cycle pulse: parity mismatch, frame dropped
//  stp_err     out  1           1-cycle pulse: stop bit sampled 0, frame dropped
// BEHAVIOUR
//  - Reset (rst=0 at posedge): FSM=IDLE, counters=0, p_data=0, all strobes=0,
//    synchronizer flops=1. Reset mid-frame aborts the frame with no strobe.
//  - rx_in passes a 2-flop synchronizer (rx_s); all timing below is on rx_s.
//  - prescale/par_en/par_typ are captured on start detection; changes mid-frame are ignored.
//  - edge_cnt runs 0..prescale-1 per bit; bit_cnt counts data bits 0..DATA_WIDTH-1.
//  - Samples taken at edge_cnt = P/2-1, P/2, P/2+1 (P = prescale). Bit value =
//    majority of 3, decided at edge_cnt = P/2+1.
//  - FSM:
//    IDLE   : rx_s==0 -> START, edge_cnt=0 in that cycle.
//    START  : at decision, bit==1 -> IDLE (glitch, no strobe); else continue;
//             edge_cnt==P-1 -> DATA.
//    DATA   : at decision, shift bit into shift reg (LSB first);
//             edge_cnt==P-1 & bit_cnt==DATA_WIDTH-1 -> PARITY if par_en else STOP.
//    PARITY : at decision, flag mismatch: even -> ^{data,bit}!=0, odd -> ==0;
//             edge_cnt==P-1 -> STOP.
//    STOP   : at decision -> IDLE. Next cycle exactly one pulse:
//             stop bit 0 -> stp_err (takes priority; par_err suppressed);
//             else parity flagged -> par_err;
//             else data_valid, with p_data updated in the same cycle.
//  - Returning to IDLE at mid-stop lets a start edge right after the stop bit
//    be caught: back-to-back frames need no idle gap.
//  - Strobes are mutually exclusive and never last more than 1 cycle.
//  - Latency: data_valid is 2 (synchronizer) + 1 cycles after the mid-stop
//    decision point.
//  - A line held low after stp_err re-enters START on the next IDLE cycle
//    (break behaves as repeated framing errors).
// STRUCTURE
//  - uart_pkg (shared with TX): FSM state encoding, parity-type constants,
//    DATA_WIDTH default.
//  - Sub-module uart_rx_sampler: edge counter, 3-point sampler, majority vote;
//    outputs bit value and a sample_done strobe.
//  - Top level holds the synchronizer, FSM, bit counter, shift register,
//    parity check and output regs.
// TESTING
//  1 prescale=8, par_en=0, frame 0xA5 -> one data_valid, p_data=0xA5, no errors.
//  2 prescale=16, even parity, 0x3C with parity 0 -> data_valid, p_data=0x3C;
//    same frame with parity 1 -> par_err pulse, no data_valid, p_data unchanged.
//  3 prescale=8, 0x55 with stop=0 -> stp_err pulse only; a following good frame
//    0x0F -> data_valid, p_data=0x0F.
//  4 prescale=16, idle line with a 3-clock low glitch -> FSM returns to IDLE,
//    no strobe; a real frame 0x81 afterwards is received correctly.
//  5 prescale=32, odd parity, back-to-back 0x01 then 0xFE, no gap ->
//    two data_valid pulses in order, no errors.
//  6 rst=0 asserted mid-DATA of 0xC3, then released and a frame 0x7E sent ->
//    no strobe for the aborted frame, then data_valid with p_data=0x7E.
//    Bench also checks ±1 clock/bit of skew at prescale=16 with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type constants and the default data width.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter plus 3-point mid-bit sampler with majority vote.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_s_i,
    input  logic                  cnt_en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  bit_o,
    output logic                  sample_done_o,
    output logic                  bit_end_o
);

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic [PRESCALE_W-1:0] half;

    assign half          = prescale_i >> 1;
    assign bit_end_o     = (edge_q == prescale_i - PRESCALE_W'(1));
    assign sample_done_o = (edge_q == half + PRESCALE_W'(1));
    assign bit_o         = (s0_q & s1_q) | (s0_q & rx_s_i) | (s1_q & rx_s_i);

    always_comb begin
        edge_d = '0;
        s0_d   = s0_q;
        s1_d   = s1_q;
        // Counter sits at 0 whenever the FSM is (or is about to be) idle.
        if (cnt_en_i && !bit_end_o) edge_d = edge_q + PRESCALE_W'(1);
        if (edge_q == half - PRESCALE_W'(1)) s0_d = rx_s_i;
        if (edge_q == half)                  s1_d = rx_s_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            edge_q <= '0;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else begin
            edge_q <= edge_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity/stop checks and output strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e           state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_flag_q, par_flag_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;

    logic bit_val, sample_done, bit_end, cnt_en;

    assign cnt_en = (state_d != ST_IDLE);

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk_i         (clk),
        .rst_ni        (rst),
        .rx_s_i        (rx_s_q),
        .cnt_en_i      (cnt_en),
        .prescale_i    (prescale_q),
        .bit_o         (bit_val),
        .sample_done_o (sample_done),
        .bit_end_o     (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_flag_d = par_flag_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Frame config is frozen here so mid-frame changes cannot corrupt it.
                if (!rx_s_q) begin
                    state_d    = ST_START;
                    prescale_d = prescale;
                    par_en_d   = par_en;
                    par_typ_d  = par_typ;
                end
            end
            ST_START: begin
                if (sample_done && bit_val) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d    = ST_DATA;
                    bit_cnt_d  = '0;
                    par_flag_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (sample_done) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH-1))
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    else
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (sample_done)
                    par_flag_d = (par_typ_q == PAR_ODD) ? ~(^{shift_q, bit_val})
                                                        :  (^{shift_q, bit_val});
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (sample_done) begin
                    state_d = ST_IDLE;
                    if (!bit_val) begin
                        serr_d = 1'b1;
                    end else if (par_flag_q) begin
                        perr_d = 1'b1;
                    end else begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_flag_q <= 1'b0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_in;
            rx_s_q     <= rx_meta_q;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_flag_q <= par_flag_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = perr_q;
    assign stp_err    = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed-frame bench for uart_rx; expected strobes go into a queue, a monitor pops and compares.
module tb_uart_rx;

    localparam logic [1:0] K_DV = 2'd0, K_PAR = 2'd1, K_STP = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid, par_err, stp_err;

    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && (data_valid || par_err || stp_err)) begin
            exp_t       e;
            logic [1:0] k;
            k = data_valid ? K_DV : (par_err ? K_PAR : K_STP);
            n_vec++;
            if ((int'(data_valid) + int'(par_err) + int'(stp_err)) > 1) begin
                n_err++;
                $display("FAIL onehot: dv=%0b perr=%0b serr=%0b, need one strobe", data_valid, par_err, stp_err);
            end
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected strobe kind=%0d p_data=%02h at %0t", k, p_data, $time);
            end else begin
                e = exp_q.pop_front();
                if (k != e.kind) begin
                    n_err++;
                    $display("FAIL kind: got %0d, need %0d (exp data %02h)", k, e.kind, e.data);
                end
                n_vec++;
                if (p_data !== e.data) begin
                    n_err++;
                    $display("FAIL p_data: got %02h, need %02h (kind %0d)", p_data, e.data, e.kind);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx_in = b;
        tick(n);
    endtask

    // Bit periods alternate p+jit / p-jit so drift stays within one clock.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                              input bit bad_par, input bit stop_b, input int jit, input int gap);
        logic pb;
        int   k;
        k = 0;
        prescale = 6'(p);
        par_en   = pe;
        par_typ  = pt;
        drive_bit(1'b0, p + ((k % 2 == 0) ? jit : -jit)); k++;
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], p + ((k % 2 == 0) ? jit : -jit)); k++;
        end
        if (pe) begin
            pb = pt ? ~(^d) : (^d);
            if (bad_par) pb = ~pb;
            drive_bit(pb, p + ((k % 2 == 0) ? jit : -jit)); k++;
        end
        drive_bit(stop_b, p + ((k % 2 == 0) ? jit : -jit));
        if (gap > 0) drive_bit(1'b1, gap);
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = (kind == K_DV) ? d : last_good;
        if (kind == K_DV) last_good = d;
        exp_q.push_back(e);
    endtask

    initial begin
        rst   = 1'b0;
        rx_in = 1'b1;
        tick(5);
        @(negedge clk);
        n_vec++;
        if (p_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset p_data: got %02h, need 00", p_data);
        end
        n_vec++;
        if ({data_valid, par_err, stp_err} !== 3'b000) begin
            n_err++;
            $display("FAIL reset strobes: got %03b, need 000", {data_valid, par_err, stp_err});
        end
        tick(1);
        rst = 1'b1;
        tick(10);

        // 1: plain 8N1
        expect_ev(K_DV, 8'hA5);
        send_frame(8'hA5, 8, 0, 0, 0, 1, 0, 20);

        // 2: even parity good, then bad parity
        expect_ev(K_DV, 8'h3C);
        send_frame(8'h3C, 16, 1, 0, 0, 1, 0, 40);
        expect_ev(K_PAR, 8'h3C);
        send_frame(8'h3C, 16, 1, 0, 1, 1, 0, 40);

        // 3: stop bit low, then a good frame
        expect_ev(K_STP, 8'h55);
        send_frame(8'h55, 8, 0, 0, 0, 0, 0, 20);
        expect_ev(K_DV, 8'h0F);
        send_frame(8'h0F, 8, 0, 0, 0, 1, 0, 20);

        // 4: short low glitch on idle line, then a real frame
        prescale = 6'd16;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 40);
        expect_ev(K_DV, 8'h81);
        send_frame(8'h81, 16, 0, 0, 0, 1, 0, 40);

        // 5: odd parity, back-to-back
        expect_ev(K_DV, 8'h01);
        send_frame(8'h01, 32, 1, 1, 0, 1, 0, 0);
        expect_ev(K_DV, 8'hFE);
        send_frame(8'hFE, 32, 1, 1, 0, 1, 0, 70);

        // 6: reset mid-DATA of 0xC3 aborts silently
        prescale = 6'd16;
        par_en   = 1'b0;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 8);
        rx_in = 1'b1;
        rst   = 1'b0;
        tick(3);
        rst = 1'b1;
        last_good = 8'h00;
        tick(30);
        expect_ev(K_DV, 8'h7E);
        send_frame(8'h7E, 16, 0, 0, 0, 1, 0, 40);

        // bit-period skew of +/-1 clock at prescale 16
        expect_ev(K_DV, 8'h96);
        send_frame(8'h96, 16, 1, 0, 0, 1, 1, 40);
        expect_ev(K_DV, 8'h6B);
        send_frame(8'h6B, 16, 0, 0, 0, 1, -1, 40);

        tick(100);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected strobes never seen, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
